// File: rtl/lc4_mdu_pkg.sv
// Shared types and op encodings for the LC4 iterative multiply/divide unit.
package lc4_mdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam logic MDU_MULU = 1'b0;
    localparam logic MDU_DIVU = 1'b1;

endpackage

// File: rtl/lc4_mdu_step.sv
// One radix-2 iteration of the shift-add multiplier or restoring divider.
module lc4_mdu_step
    import lc4_mdu_pkg::*;
#(
    parameter int WORD_SIZE = 64
) (
    input  logic                 op,
    input  logic [WORD_SIZE-1:0] hi,
    input  logic [WORD_SIZE-1:0] lo,
    input  logic [WORD_SIZE-1:0] opb,
    output logic [WORD_SIZE-1:0] hi_next,
    output logic [WORD_SIZE-1:0] lo_next
);

    logic [WORD_SIZE:0] sum_s;
    logic [WORD_SIZE:0] prem_s;
    logic [WORD_SIZE:0] diff_s;

    // Partial remainder keeps the bit shifted out of rem so divisors with the MSB set stay exact.
    always_comb begin
        sum_s   = lo[0] ? ({1'b0, hi} + {1'b0, opb}) : {1'b0, hi};
        prem_s  = {hi, lo[WORD_SIZE-1]};
        diff_s  = prem_s - {1'b0, opb};
        hi_next = hi;
        lo_next = lo;
        case (op)
            MDU_MULU: begin
                hi_next = sum_s[WORD_SIZE:1];
                lo_next = {sum_s[0], lo[WORD_SIZE-1:1]};
            end
            MDU_DIVU: begin
                if (!diff_s[WORD_SIZE]) begin
                    hi_next = diff_s[WORD_SIZE-1:0];
                    lo_next = {lo[WORD_SIZE-2:0], 1'b1};
                end else begin
                    hi_next = prem_s[WORD_SIZE-1:0];
                    lo_next = {lo[WORD_SIZE-2:0], 1'b0};
                end
            end
            default: begin
                hi_next = hi;
                lo_next = lo;
            end
        endcase
    end

endmodule

// File: rtl/lc4_mdu.sv
// LC4 multi-cycle unsigned multiply/divide unit: FSM, iteration counter and
// result registers around the single-step datapath.
module lc4_mdu
    import lc4_mdu_pkg::*;
#(
    parameter int WORD_SIZE = 64,
    parameter int TAG_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_op,
    input  logic [WORD_SIZE-1:0] i_r1data,
    input  logic [WORD_SIZE-1:0] i_r2data,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [WORD_SIZE-1:0] o_lo,
    output logic [WORD_SIZE-1:0] o_hi,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_dbz
);

    localparam int CNT_W = $clog2(WORD_SIZE) + 1;

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic [WORD_SIZE-1:0] opb_q, opb_d;
    logic [WORD_SIZE-1:0] acc_hi_q, acc_hi_d;
    logic [WORD_SIZE-1:0] acc_lo_q, acc_lo_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] res_lo_q, res_lo_d;
    logic [WORD_SIZE-1:0] res_hi_q, res_hi_d;
    logic [TAG_W-1:0]     res_tag_q, res_tag_d;
    logic                 dbz_q, dbz_d;

    logic [WORD_SIZE-1:0] step_hi_s;
    logic [WORD_SIZE-1:0] step_lo_s;

    lc4_mdu_step #(
        .WORD_SIZE (WORD_SIZE)
    ) u_step (
        .op      (op_q),
        .hi      (acc_hi_q),
        .lo      (acc_lo_q),
        .opb     (opb_q),
        .hi_next (step_hi_s),
        .lo_next (step_lo_s)
    );

    // Next-state, datapath loads and registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        tag_d     = tag_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        res_tag_d = res_tag_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    busy_d = 1'b1;
                    tag_d  = i_tag;
                    if ((i_op == MDU_DIVU) && (i_r2data == {WORD_SIZE{1'b0}})) begin
                        state_d   = ST_DONE;
                        valid_d   = 1'b1;
                        res_lo_d  = {WORD_SIZE{1'b1}};
                        res_hi_d  = i_r1data;
                        res_tag_d = i_tag;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        cnt_d    = CNT_W'(WORD_SIZE);
                        op_d     = i_op;
                        acc_hi_d = {WORD_SIZE{1'b0}};
                        // Multiplier (r2) sits in lo for MULU; dividend (r1) for DIVU.
                        acc_lo_d = (i_op == MDU_DIVU) ? i_r1data : i_r2data;
                        opb_d    = (i_op == MDU_DIVU) ? i_r2data : i_r1data;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_d   = 1'b1;
                acc_hi_d = step_hi_s;
                acc_lo_d = step_lo_s;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    valid_d   = 1'b1;
                    res_lo_d  = step_lo_s;
                    res_hi_d  = step_hi_s;
                    res_tag_d = tag_q;
                    dbz_d     = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= MDU_MULU;
            opb_q     <= {WORD_SIZE{1'b0}};
            acc_hi_q  <= {WORD_SIZE{1'b0}};
            acc_lo_q  <= {WORD_SIZE{1'b0}};
            tag_q     <= {TAG_W{1'b0}};
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            res_lo_q  <= {WORD_SIZE{1'b0}};
            res_hi_q  <= {WORD_SIZE{1'b0}};
            res_tag_q <= {TAG_W{1'b0}};
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            tag_q     <= tag_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            res_tag_q <= res_tag_d;
            dbz_q     <= dbz_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_lo    = res_lo_q;
    assign o_hi    = res_hi_q;
    assign o_tag   = res_tag_q;
    assign o_dbz   = dbz_q;

endmodule

// File: tb/tb_lc4_mdu.sv
// Self-checking bench for lc4_mdu: a 16-bit and a 64-bit instance checked
// against an arithmetic reference model with directed and random operations.
module tb_lc4_mdu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start16, op16;
    logic [15:0] r1_16, r2_16;
    logic [2:0]  tag16;
    logic        busy16, valid16, dbz16;
    logic [15:0] lo16, hi16;
    logic [2:0]  tago16;

    logic        start64, op64;
    logic [63:0] r1_64, r2_64;
    logic [2:0]  tag64;
    logic        busy64, valid64, dbz64;
    logic [63:0] lo64, hi64;
    logic [2:0]  tago64;

    lc4_mdu #(.WORD_SIZE(16), .TAG_W(3)) u_dut16 (
        .clk(clk), .rst(rst), .i_start(start16), .i_op(op16),
        .i_r1data(r1_16), .i_r2data(r2_16), .i_tag(tag16),
        .o_busy(busy16), .o_valid(valid16), .o_lo(lo16), .o_hi(hi16),
        .o_tag(tago16), .o_dbz(dbz16)
    );

    lc4_mdu #(.WORD_SIZE(64), .TAG_W(3)) u_dut64 (
        .clk(clk), .rst(rst), .i_start(start64), .i_op(op64),
        .i_r1data(r1_64), .i_r2data(r2_64), .i_tag(tag64),
        .o_busy(busy64), .o_valid(valid64), .o_lo(lo64), .o_hi(hi64),
        .o_tag(tago64), .o_dbz(dbz64)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        v_busy, v_valid, v_dbz;
    logic [63:0] v_lo, v_hi;
    logic [2:0]  v_tag;

    logic [63:0] last_lo [2];
    logic [63:0] last_hi [2];
    logic        last_dbz [2];
    logic [2:0]  last_tag [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int s, input logic st, input logic op,
                         input logic [63:0] a, input logic [63:0] b, input logic [2:0] tg);
        if (s == 0) begin
            start16 = st; op16 = op; r1_16 = a[15:0]; r2_16 = b[15:0]; tag16 = tg;
        end else begin
            start64 = st; op64 = op; r1_64 = a; r2_64 = b; tag64 = tg;
        end
    endtask

    task automatic snap(input int s);
        if (s == 0) begin
            v_busy = busy16; v_valid = valid16; v_dbz = dbz16;
            v_lo = {48'h0, lo16}; v_hi = {48'h0, hi16}; v_tag = tago16;
        end else begin
            v_busy = busy64; v_valid = valid64; v_dbz = dbz64;
            v_lo = lo64; v_hi = hi64; v_tag = tago64;
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    endfunction

    // Reference: plain double-width product and integer quotient/remainder.
    task automatic model(input int w, input logic op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] elo, output logic [63:0] ehi, output logic edbz);
        logic [127:0] p;
        p = {64'h0, a} * {64'h0, b};
        edbz = 1'b0;
        if (op == 1'b0) begin
            elo = p[63:0] & wmask(w);
            ehi = (w == 64) ? p[127:64] : ({32'h0, p[31:0]} >> 16);
        end else if (b == 64'h0) begin
            elo = wmask(w);
            ehi = a;
            edbz = 1'b1;
        end else begin
            elo = a / b;
            ehi = a % b;
        end
    endtask

    task automatic clear_last();
        for (int i = 0; i < 2; i++) begin
            last_lo[i] = 64'h0; last_hi[i] = 64'h0; last_dbz[i] = 1'b0; last_tag[i] = 3'h0;
        end
    endtask

    task automatic run_op(input int s, input logic op, input logic [63:0] a_in,
                          input logic [63:0] b_in, input logic [2:0] tg, input int inject_at);
        int w, cyc, lat, exp_lat;
        logic [63:0] a, b, elo, ehi;
        logic edbz, held, busy_ok;
        w = (s == 0) ? 16 : 64;
        a = a_in & wmask(w);
        b = b_in & wmask(w);
        model(w, op, a, b, elo, ehi, edbz);
        exp_lat = (op && (b == 64'h0)) ? 1 : w + 1;
        @(negedge clk);
        drive(s, 1'b1, op, a, b, tg);
        cyc = 0; lat = -1; held = 1'b1; busy_ok = 1'b1;
        while (lat < 0 && cyc < w + 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(s, 1'b0, ~op, {$urandom, $urandom}, {$urandom, $urandom}, ~tg);
            if (cyc == inject_at) drive(s, 1'b1, 1'b0, ~a, 64'h3, tg + 3'd1);
            if (cyc == inject_at + 1) drive(s, 1'b0, 1'b0, 64'h0, 64'h0, 3'h0);
            snap(s);
            if (!v_busy) busy_ok = 1'b0;
            if (v_valid) begin
                lat = cyc;
            end else if (v_lo !== last_lo[s] || v_hi !== last_hi[s] ||
                         v_dbz !== last_dbz[s] || v_tag !== last_tag[s]) begin
                held = 1'b0;
            end
        end
        check_val("latency", 64'(lat), 64'(exp_lat));
        check_val("lo", v_lo, elo);
        check_val("hi", v_hi, ehi);
        check_val("dbz", {63'h0, v_dbz}, {63'h0, edbz});
        check_val("tag", {61'h0, v_tag}, {61'h0, tg});
        check_val("busy", {63'h0, busy_ok}, 64'h1);
        check_val("hold", {63'h0, held}, 64'h1);
        @(negedge clk);
        snap(s);
        check_val("pulse", {62'h0, v_valid, v_busy}, 64'h0);
        last_lo[s] = elo; last_hi[s] = ehi; last_dbz[s] = edbz; last_tag[s] = tg;
    endtask

    task automatic reset_mid_op();
        logic saw_valid;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321, 3'h6);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) drive(1, 1'b0, 1'b0, 64'h0, 64'h0, 3'h0);
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        snap(1);
        check_val("rst_ctl", {62'h0, v_valid, v_busy}, 64'h0);
        check_val("rst_lo", v_lo, 64'h0);
        check_val("rst_hi", v_hi, 64'h0);
        check_val("rst_tagdbz", {60'h0, v_tag, v_dbz}, 64'h0);
        saw_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            snap(1);
            if (v_valid || v_busy) saw_valid = 1'b1;
        end
        check_val("rst_quiet", {63'h0, saw_valid}, 64'h0);
        clear_last();
        run_op(1, 1'b1, 64'd9, 64'd2, 3'h2, -1);
    endtask

    initial begin
        logic [63:0] a, b;
        logic op;
        int mode;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 64'h0, 64'h0, 3'h0);
        drive(1, 1'b0, 1'b0, 64'h0, 64'h0, 3'h0);
        clear_last();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            snap(s);
            check_val("reset_ctl", {62'h0, v_valid, v_busy}, 64'h0);
            check_val("reset_out", v_lo | v_hi | {60'h0, v_tag, v_dbz}, 64'h0);
        end

        run_op(0, 1'b0, 64'hFFFF, 64'hFFFF, 3'h5, -1);
        check_val("ffff_hi", last_hi[0], 64'hFFFE);
        run_op(1, 1'b1, 64'd1000, 64'd7, 3'h1, -1);
        run_op(1, 1'b1, 64'h1234, 64'h0, 3'h3, -1);
        run_op(0, 1'b0, 64'h1234, 64'h0567, 3'h4, 3);
        run_op(0, 1'b1, 64'h0005, 64'hFFFF, 3'h7, -1);
        run_op(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'h0, -1);
        run_op(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 3'h2, -1);
        reset_mid_op();

        for (int i = 0; i < 1250; i++) begin
            int s;
            s = (i < 1000) ? 0 : 1;
            op = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 64'h0;
                1: a = 64'h0;
                2: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = ~b; end
                3: b = 64'($urandom_range(1, 15));
                4: b = {1'b1, b[62:0]} | 64'h8000;
                default: ;
            endcase
            run_op(s, op, a, b, 3'($urandom_range(0, 7)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
